pulse_height_classifier: RTL and testbench

PULSE_HEIGHT_CLASSIFIER -- requirements
Module: pulse_height_classifier

---
 rtl/pulse_height_classifier.sv | 201 ++++++++++++++++++++
 tb/tb_pulse_height_classifier.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_height_classifier.sv
// Pulse height classifier: arms on a threshold crossing, tracks the pulse peak and width,
// and reports a classified event plus per-class counters when the pulse releases or times out.
module pulse_height_classifier #(
    parameter  int DW      = 14,
    parameter  int NBINS   = 2,
    parameter  int MIN_LEN = 2,
    parameter  int MAX_LEN = 255,
    parameter  int CNT_W   = 16,
    localparam int CODE_W  = $clog2(NBINS + 1),
    localparam int WW      = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [DW-1:0]             sigin,
    input  logic [DW-1:0]             arm_thr,
    input  logic [DW-1:0]             rel_thr,
    input  logic [DW-1:0]             rearm_thr,
    input  logic [(NBINS-1)*DW-1:0]   bin_thr,
    input  logic                      cnt_clr,
    output logic                      evt_valid,
    output logic [CODE_W-1:0]         evt_class,
    output logic [DW-1:0]             evt_peak,
    output logic [WW-1:0]             evt_width,
    output logic                      evt_err,
    output logic [NBINS*CNT_W-1:0]    cnt_bus
);

    localparam logic [WW-1:0] MIN_W = WW'(MIN_LEN);
    localparam logic [WW-1:0] MAX_W = WW'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t state, state_nx;

    logic signed [DW-1:0]       x;
    logic signed [DW-1:0]       peak;
    logic signed [DW-1:0]       peak_max;
    logic signed [DW-1:0]       rel_sh;
    logic [(NBINS-1)*DW-1:0]    bin_sh;
    logic [WW-1:0]              width;
    logic                       do_arm;
    logic                       do_emit;
    logic                       emit_err;
    logic [CODE_W-1:0]          class_code;

    logic                       pend_valid;
    logic                       pend_err;
    logic [CODE_W-1:0]          pend_class;
    logic signed [DW-1:0]       pend_peak;
    logic [WW-1:0]              pend_width;

    logic [CNT_W-1:0]           cnt [NBINS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
        end else begin
            x <= sigin;
        end
    end

    // The reported peak always includes the sample that ends the pulse.
    assign peak_max = (x > peak) ? x : peak;

    always_comb begin
        class_code = CODE_W'(1);
        for (int j = 0; j < NBINS - 1; j++) begin
            if ($signed(bin_sh[j*DW +: DW]) < peak_max) begin
                class_code = class_code + CODE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        do_arm   = 1'b0;
        do_emit  = 1'b0;
        emit_err = 1'b0;
        case (state)
            IDLE: begin
                if (en && (x > $signed(arm_thr))) begin
                    state_nx = ARMED;
                    do_arm   = 1'b1;
                end
            end
            ARMED: begin
                // Release takes priority over timeout; short pulses vanish without an event.
                if (!en) begin
                    state_nx = IDLE;
                end else if (x < rel_sh) begin
                    state_nx = HOLDOFF;
                    do_emit  = (width >= MIN_W);
                end else if (width == MAX_W) begin
                    state_nx = HOLDOFF;
                    do_emit  = 1'b1;
                    emit_err = 1'b1;
                end
            end
            HOLDOFF: begin
                if (!en || (x < $signed(rearm_thr))) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Release and class thresholds are frozen at arm time so mid-pulse edits cannot split a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak   <= '0;
            width  <= '0;
            rel_sh <= '0;
            bin_sh <= '0;
        end else if (do_arm) begin
            peak   <= x;
            width  <= WW'(1);
            rel_sh <= rel_thr;
            bin_sh <= bin_thr;
        end else if (state == ARMED) begin
            peak <= peak_max;
            if (width != MAX_W) begin
                width <= width + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            pend_class <= '0;
            pend_peak  <= '0;
            pend_width <= '0;
        end else begin
            pend_valid <= do_emit;
            pend_err   <= do_emit & emit_err;
            pend_class <= do_emit ? class_code : '0;
            pend_peak  <= do_emit ? peak_max : '0;
            pend_width <= do_emit ? width : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_class <= '0;
            evt_peak  <= '0;
            evt_width <= '0;
            evt_err   <= 1'b0;
        end else begin
            evt_valid <= pend_valid;
            evt_class <= pend_class;
            evt_peak  <= pend_peak;
            evt_width <= pend_width;
            evt_err   <= pend_err;
        end
    end

    // Counters step on the same edge that raises evt_valid; a clear overrides that step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NBINS; c++) begin
                cnt[c] <= '0;
            end
        end else if (cnt_clr) begin
            for (int c = 0; c < NBINS; c++) begin
                cnt[c] <= '0;
            end
        end else if (pend_valid && !pend_err) begin
            for (int c = 0; c < NBINS; c++) begin
                if ((pend_class == CODE_W'(c + 1)) && (cnt[c] != {CNT_W{1'b1}})) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_bus = '0;
        for (int c = 0; c < NBINS; c++) begin
            cnt_bus[c*CNT_W +: CNT_W] = cnt[c];
        end
    end

endmodule

// File: tb/tb_pulse_height_classifier.sv
// Bench for pulse_height_classifier: two instances (2 classes/16-bit counters and 4 classes/3-bit
// counters) share stimulus and are compared every cycle against a pulse-level reference model.
module tb_pulse_height_classifier;

    localparam int DW = 14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            cnt_clr;
    logic [DW-1:0]   sigin;
    logic [DW-1:0]   arm_thr;
    logic [DW-1:0]   rel_thr;
    logic [DW-1:0]   rearm_thr;
    logic [DW-1:0]   bin_a;
    logic [3*DW-1:0] bin_b;

    logic            va, ea, vb, eb;
    logic [1:0]      ca;
    logic [2:0]      cb;
    logic [DW-1:0]   pa, pb;
    logic [7:0]      wa, wb;
    logic [31:0]     cnt_a;
    logic [11:0]     cnt_b;

    pulse_height_classifier #(.DW(DW), .NBINS(2), .MIN_LEN(2), .MAX_LEN(255), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sigin(sigin), .arm_thr(arm_thr), .rel_thr(rel_thr),
        .rearm_thr(rearm_thr), .bin_thr(bin_a), .cnt_clr(cnt_clr), .evt_valid(va), .evt_class(ca),
        .evt_peak(pa), .evt_width(wa), .evt_err(ea), .cnt_bus(cnt_a)
    );

    pulse_height_classifier #(.DW(DW), .NBINS(4), .MIN_LEN(2), .MAX_LEN(255), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sigin(sigin), .arm_thr(arm_thr), .rel_thr(rel_thr),
        .rearm_thr(rearm_thr), .bin_thr(bin_b), .cnt_clr(cnt_clr), .evt_valid(vb), .evt_class(cb),
        .evt_peak(pb), .evt_width(wb), .evt_err(eb), .cnt_bus(cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct {
        bit v;
        int pk;
        int w;
        bit err;
        int ca;
        int cb;
    } ev_t;

    // Reference model: a pulse is tracked as (active, peak, length, frozen thresholds).
    int  mx = 0;
    bit  in_pulse = 0;
    bit  waiting_low = 0;
    int  m_pk = 0, m_len = 0, m_rel = 0, m_bina = 0;
    int  m_binb[3];
    int  cnta[2];
    int  cntb[4];
    ev_t st1, outv, m_last;
    int  m_events = 0;

    int  d_events = 0, d_pk = 0, d_w = 0, d_ca = 0, d_cb = 0;
    bit  d_err = 0;

    function automatic ev_t noEvent();
        ev_t e;
        e.v = 0; e.pk = 0; e.w = 0; e.err = 0; e.ca = 0; e.cb = 0;
        return e;
    endfunction

    function automatic ev_t makeEvent(int pk, int len, bit err);
        ev_t e;
        e.v = 1; e.pk = pk; e.w = len; e.err = err;
        e.ca = 1 + ((m_bina < pk) ? 1 : 0);
        e.cb = 1;
        for (int j = 0; j < 3; j++) if (m_binb[j] < pk) e.cb++;
        return e;
    endfunction

    task automatic modelStep();
        int pk;
        if (!rst_n) begin
            mx = 0; in_pulse = 0; waiting_low = 0;
            m_pk = 0; m_len = 0; m_rel = 0; m_bina = 0;
            for (int j = 0; j < 3; j++) m_binb[j] = 0;
            for (int c = 0; c < 2; c++) cnta[c] = 0;
            for (int c = 0; c < 4; c++) cntb[c] = 0;
            st1 = noEvent();
            outv = noEvent();
            return;
        end
        if (cnt_clr) begin
            for (int c = 0; c < 2; c++) cnta[c] = 0;
            for (int c = 0; c < 4; c++) cntb[c] = 0;
        end else if (st1.v && !st1.err) begin
            if (cnta[st1.ca-1] < 65535) cnta[st1.ca-1]++;
            if (cntb[st1.cb-1] < 7) cntb[st1.cb-1]++;
        end
        outv = st1;
        if (outv.v) begin
            m_events++;
            m_last = outv;
        end
        st1 = noEvent();
        if (in_pulse) begin
            pk = (mx > m_pk) ? mx : m_pk;
            if (!en) begin
                in_pulse = 0;
            end else if (mx < m_rel) begin
                in_pulse = 0; waiting_low = 1;
                if (m_len >= 2) st1 = makeEvent(pk, m_len, 1'b0);
            end else if (m_len == 255) begin
                in_pulse = 0; waiting_low = 1;
                st1 = makeEvent(pk, m_len, 1'b1);
            end else begin
                m_pk = pk;
                m_len++;
            end
        end else if (waiting_low) begin
            if (!en || (mx < $signed(rearm_thr))) waiting_low = 0;
        end else if (en && (mx > $signed(arm_thr))) begin
            in_pulse = 1; m_pk = mx; m_len = 1;
            m_rel  = $signed(rel_thr);
            m_bina = $signed(bin_a);
            for (int j = 0; j < 3; j++) m_binb[j] = $signed(bin_b[j*DW +: DW]);
        end
        mx = $signed(sigin);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        modelStep();
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (started) begin
            checkOutput("evtA", longint'({va, ca, pa, wa, ea}),
                        longint'({outv.v, 2'(outv.ca), 14'(outv.pk), 8'(outv.w), outv.err}));
            checkOutput("evtB", longint'({vb, cb, pb, wb, eb}),
                        longint'({outv.v, 3'(outv.cb), 14'(outv.pk), 8'(outv.w), outv.err}));
            checkOutput("cntA", longint'(cnt_a), longint'({16'(cnta[1]), 16'(cnta[0])}));
            checkOutput("cntB", longint'(cnt_b),
                        longint'({3'(cntb[3]), 3'(cntb[2]), 3'(cntb[1]), 3'(cntb[0])}));
            if (va) begin
                d_events++;
                d_ca = int'(ca); d_pk = int'($signed(pa)); d_w = int'(wa); d_err = ea;
            end
            if (vb) d_cb = int'(cb);
        end
    end

    task automatic applyStimulus(input int s);
        sigin = DW'(s);
        @(negedge clk);
    endtask

    task automatic runPulse(input int peak_val);
        applyStimulus(600);
        applyStimulus(peak_val);
        applyStimulus(150);
        repeat (4) applyStimulus(0);
    endtask

    task automatic randomizeThresholds();
        int b0, b1, b2;
        arm_thr   = DW'($urandom_range(400, 700));
        rel_thr   = DW'($urandom_range(100, 450));
        rearm_thr = DW'($urandom_range(0, 200));
        bin_a     = DW'($urandom_range(800, 2500));
        b0 = int'($urandom_range(500, 1500));
        b1 = b0 + int'($urandom_range(0, 1000));
        b2 = b1 + int'($urandom_range(0, 1500));
        bin_b = {DW'(b2), DW'(b1), DW'(b0)};
    endtask

    initial begin
        int ev0;
        rst_n = 1'b0; en = 1'b1; cnt_clr = 1'b0; sigin = '0;
        arm_thr = 14'd500; rel_thr = 14'd200; rearm_thr = 14'd100;
        bin_a = 14'd1500;
        bin_b = {14'd3000, 14'd2000, 14'd1000};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        started = 1'b1;
        #1;
        checkOutput("reset_valid", longint'(va), 0);
        checkOutput("reset_cntA", longint'(cnt_a), 0);
        @(negedge clk);

        // Basic class-1 pulse
        ev0 = d_events;
        applyStimulus(0); applyStimulus(600); applyStimulus(900); applyStimulus(700);
        applyStimulus(150); repeat (4) applyStimulus(0);
        #1;
        checkOutput("basic_events", d_events - ev0, 1);
        checkOutput("basic_class", d_ca, 1);
        checkOutput("basic_peak", d_pk, 900);
        checkOutput("basic_width", d_w, 3);
        checkOutput("basic_err", longint'(d_err), 0);
        checkOutput("basic_cnt", longint'(cnt_a), 64'h0000_0001);
        checkOutput("model_basic_peak", m_last.pk, 900);
        checkOutput("model_basic_width", m_last.w, 3);

        // Above and exactly on the class boundary
        applyStimulus(0); applyStimulus(600); applyStimulus(1600); applyStimulus(1501);
        applyStimulus(150); repeat (4) applyStimulus(0);
        #1;
        checkOutput("upper_class", d_ca, 2);
        checkOutput("upper_peak", d_pk, 1600);
        checkOutput("model_upper_class", m_last.ca, 2);
        runPulse(1500);
        #1;
        checkOutput("boundary_class", d_ca, 1);
        checkOutput("boundary_cnt", longint'(cnt_a), 64'h0001_0002);

        // Too-short pulse is discarded
        ev0 = d_events;
        applyStimulus(600); applyStimulus(150); repeat (4) applyStimulus(50);
        #1;
        checkOutput("short_events", d_events - ev0, 0);
        checkOutput("short_cnt", longint'(cnt_a), 64'h0001_0002);

        // Timeout on a held level, then no re-arm until the level drops below rearm
        ev0 = d_events;
        sigin = DW'(800);
        repeat (300) @(negedge clk);
        repeat (5) applyStimulus(600);
        #1;
        checkOutput("timeout_events", d_events - ev0, 1);
        checkOutput("timeout_err", longint'(d_err), 1);
        checkOutput("timeout_width", d_w, 255);
        checkOutput("timeout_peak", d_pk, 800);
        checkOutput("timeout_cnt", longint'(cnt_a), 64'h0001_0002);
        repeat (3) applyStimulus(50);

        // Enable dropped mid-pulse
        ev0 = d_events;
        applyStimulus(600); applyStimulus(900);
        en = 1'b0;
        applyStimulus(900); applyStimulus(150);
        en = 1'b1;
        repeat (4) applyStimulus(0);
        #1;
        checkOutput("en_abort_events", d_events - ev0, 0);

        // Reset mid-pulse
        applyStimulus(600); applyStimulus(900);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", longint'(va), 0);
        checkOutput("rst_mid_cnt", longint'(cnt_a), 0);
        sigin = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(0);

        // Clear coinciding with the counting edge
        runPulse(900);
        applyStimulus(600); applyStimulus(900); applyStimulus(150); applyStimulus(0);
        cnt_clr = 1'b1;
        applyStimulus(0);
        cnt_clr = 1'b0;
        #1;
        checkOutput("clr_coincident_valid", longint'(va), 1);
        checkOutput("clr_coincident_cnt", longint'(cnt_a), 0);
        repeat (3) applyStimulus(0);

        // Four-class instance
        runPulse(999);  #1; checkOutput("b_class_999", d_cb, 1);
        runPulse(1001); #1; checkOutput("b_class_1001", d_cb, 2);
        runPulse(2500); #1; checkOutput("b_class_2500", d_cb, 3);
        checkOutput("a_class_2500", d_ca, 2);
        runPulse(3001); #1; checkOutput("b_class_3001", d_cb, 4);
        checkOutput("model_b_class_3001", m_last.cb, 4);
        ev0 = d_events;
        repeat (4) applyStimulus(-10);
        repeat (3) applyStimulus(0);
        #1;
        checkOutput("below_arm_events", d_events - ev0, 0);

        // Randomized levels, thresholds, enable and clear
        for (int n = 0; n < 800; n++) begin
            int lvl, hold, r;
            r = int'($urandom_range(0, 9));
            if (r < 3)      lvl = int'($urandom_range(0, 150)) - 100;
            else if (r < 5) lvl = int'($urandom_range(150, 450));
            else            lvl = int'($urandom_range(500, 4000));
            hold = int'($urandom_range(1, 4));
            for (int h = 0; h < hold; h++) begin
                en      = ($urandom_range(0, 99) != 0);
                cnt_clr = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 59) == 0) randomizeThresholds();
                applyStimulus(lvl);
            end
        end
        en = 1'b1;
        cnt_clr = 1'b0;
        repeat (6) applyStimulus(0);
        #1;
        checkOutput("model_event_total", d_events, m_events);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
